// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I front end (fetch sequencing).
package cpu_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } pcseq_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_JMP  = 2'd2,
    SRC_TRAP = 2'd3
  } redir_src_t;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority select (trap > jump > branch) of the fetch redirect target.
// PC_MISALIGN_TRAP_EN: misaligned jump/branch targets divert to TRAP_VEC.
module pc_redirect_mux
  import cpu_pkg::*;
#(
  parameter int unsigned      XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  TRAP_VEC = XLEN'(32'h0000_0100)
) (
  input  logic            trap_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_target_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  output logic            redirect_c,
  output logic [XLEN-1:0] target_c
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            misalign_c
`endif
);

  redir_src_t      src_c;
  logic [XLEN-1:0] raw_c;

  always_comb begin
    src_c = SRC_NONE;
    raw_c = '0;
    if (trap_i) begin
      src_c = SRC_TRAP;
      raw_c = TRAP_VEC;
    end else if (jmp_i) begin
      src_c = SRC_JMP;
      raw_c = jmp_target_i;
    end else if (br_taken_i) begin
      src_c = SRC_BR;
      raw_c = br_target_i;
    end
  end

  assign redirect_c = (src_c != SRC_NONE);

`ifdef PC_MISALIGN_TRAP_EN
  always_comb begin
    misalign_c = ((src_c == SRC_JMP) || (src_c == SRC_BR)) && (raw_c[1:0] != 2'b00);
    target_c   = misalign_c ? TRAP_VEC : (raw_c & ~XLEN'(3));
  end
`else
  // No compressed instructions: word-align every target.
  assign target_c = raw_c & ~XLEN'(3);
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: one outstanding imem fetch, single-entry IF/ID slot, redirects.
// PC_MISALIGN_TRAP_EN adds the misalign_o pulse output.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_target_i,
  input  logic            trap_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
  output logic            flush_o
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            misalign_o
`endif
);

  pcseq_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifpc_d;
  logic [31:0]     instr_d;
  logic            valid_d, flush_d;
  logic            run_q;
  logic            redirect_c;
  logic [XLEN-1:0] target_c;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_c;
  logic misalign_d;
`endif

  pc_redirect_mux #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_redirect_mux (
    .trap_i       (trap_i),
    .jmp_i        (jmp_i),
    .jmp_target_i (jmp_target_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .redirect_c   (redirect_c),
    .target_c     (target_c)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign_c   (misalign_c)
`endif
  );

  assign imem_addr_o = pc_q;

  // State and output registers; run_q keeps the request low until the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= REQ;
      pc_q       <= RESET_VEC;
      run_q      <= 1'b0;
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
      if_instr_o <= NOP_INSTR;
      flush_o    <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      run_q      <= 1'b1;
      if_valid_o <= valid_d;
      if_pc_o    <= ifpc_d;
      if_instr_o <= instr_d;
      flush_o    <= flush_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_o <= misalign_d;
`endif
    end
  end

  // Next state, slot update and request generation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = if_valid_o;
    ifpc_d     = if_pc_o;
    instr_d    = if_instr_o;
    flush_d    = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    imem_req_o = run_q && (state_q == REQ) && (!if_valid_o || !stall_i);

    if (if_valid_o && !stall_i) valid_d = 1'b0;

    case (state_q)
      REQ: begin
        if (imem_req_o && imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          valid_d = 1'b1;
          ifpc_d  = pc_q;
          instr_d = imem_rdata_i;
          pc_d    = pc_q + XLEN'(4);
          state_d = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid_i) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    // A redirect kills the slot and any in-flight fetch; the killed response is drained in DROP.
    if (redirect_c) begin
      pc_d    = target_c;
      valid_d = 1'b0;
      ifpc_d  = if_pc_o;
      instr_d = if_instr_o;
      flush_d = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_d = misalign_c;
`endif
      case (state_q)
        REQ:     state_d = (imem_req_o && imem_gnt_i) ? DROP : REQ;
        default: state_d = imem_rvalid_i ? REQ : DROP;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a memory model answers fetches, a monitor checks consumed slots.
module tb_pc_sequencer;

  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_TGT  = 32'h0000_0100;
`else
  localparam logic [31:0] MIS_TGT  = 32'h0000_0200;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        jmp_i = 1'b0;
  logic [31:0] jmp_target_i = '0;
  logic        trap_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        flush_o;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          gnt_lat = 1;
  int          rlat = 1;
  int          gnt_count = 0;
  bit          pending = 1'b0;
  int          rcnt = 0;
  int          wcnt = 0;
  logic [31:0] paddr = '0;
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_redir = 1'b1;
  logic [31:0] prev_addr = '0;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .br_taken_i    (br_taken_i),
    .br_target_i   (br_target_i),
    .jmp_i         (jmp_i),
    .jmp_target_i  (jmp_target_i),
    .trap_i        (trap_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .flush_o       (flush_o)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_data(pc);
    sb_q.push_back(e);
  endfunction

  // Instruction memory: grant gnt_lat cycles after request, respond rlat cycles after grant.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_rvalid_i) pending = 1'b0;
      if (imem_req_o && imem_gnt_i) begin
        pending = 1'b1;
        rcnt    = rlat;
        paddr   = imem_addr_o;
        wcnt    = 0;
        gnt_count++;
      end else if (imem_req_o) begin
        wcnt++;
      end else begin
        wcnt = 0;
      end
      @(posedge clk);
      #1;
      imem_gnt_i = (wcnt >= gnt_lat) && !pending;
      imem_rvalid_i = 1'b0;
      if (pending && rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_data(paddr);
        end
      end
    end
  end

  // Monitor: every consumed slot is checked against the scoreboard; request address must hold.
  always @(negedge clk) begin
    if (reset && if_valid_o && !stall_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_slot: got pc 0x%08h, expected no output", if_pc_o);
      end else begin
        mon_e = sb_q.pop_front();
        check("if_pc", if_pc_o, mon_e.pc);
        check("if_instr", if_instr_o, mon_e.instr);
      end
    end
    if (reset && prev_req && !prev_gnt && !prev_redir && imem_req_o)
      check("addr_stable", imem_addr_o, prev_addr);
    prev_req   = imem_req_o;
    prev_gnt   = imem_gnt_i;
    prev_addr  = imem_addr_o;
    prev_redir = trap_i | jmp_i | br_taken_i | !reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending entries, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!if_valid_o && n < 100) begin
      tick();
      n++;
    end
    check({name, "_slot_valid"}, 32'(if_valid_o), 32'd1);
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    int g0 = gnt_count;
    while (gnt_count == g0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (gnt_count == g0) begin
      errors++;
      $display("FAIL %s_grant: got no grant, expected one within 100 cycles", name);
    end
  endtask

  // One-cycle redirect pulse; flush/address (and misalign) checked on the following cycles.
  task automatic redirect(input string name, input logic t, input logic j, input logic [31:0] jt,
                          input logic b, input logic [31:0] bt, input logic [31:0] exp_addr);
    trap_i = t; jmp_i = j; jmp_target_i = jt; br_taken_i = b; br_target_i = bt;
    tick();
    trap_i = 1'b0; jmp_i = 1'b0; br_taken_i = 1'b0;
    @(negedge clk);
    check({name, "_flush"}, 32'(flush_o), 32'd1);
    check({name, "_addr"}, imem_addr_o, exp_addr);
`ifdef PC_MISALIGN_TRAP_EN
    check({name, "_misalign"}, 32'(misalign_o),
          32'(!t && ((j && jt[1:0] != 2'b00) || (!j && b && bt[1:0] != 2'b00))));
`endif
    @(negedge clk);
    check({name, "_flush_end"}, 32'(flush_o), 32'd0);
    tick();
  endtask

  initial begin
    int g0;
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(if_valid_o), 32'd0);
    check("rst_pc", if_pc_o, 32'h0);
    check("rst_instr", if_instr_o, NOP);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);
    tick();
    reset = 1'b1;

    // Sequential fetch
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    wait_drain("seq");
    stall_i = 1'b1;

    // Stall holds the slot (0xC)
    wait_valid("stall");
    g0 = gnt_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_pc", if_pc_o, 32'hC);
      check("stall_instr", if_instr_o, mem_data(32'hC));
      tick();
    end
    check("stall_grants", 32'((gnt_count - g0) <= 1), 32'd1);
    expect_pc(32'hC); expect_pc(32'h10); expect_pc(32'h14);
    stall_i = 1'b0;
    wait_drain("stall_release");
    stall_i = 1'b1;

    // Branch while a fetch (0x1C) is outstanding
    rlat = 4;
    wait_valid("br");
    expect_pc(32'h18);
    stall_i = 1'b0;
    wait_grant("br");
    stall_i = 1'b1;
    redirect("br", 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 32'h200);
    @(negedge clk);
    check("br_drop_no_req", 32'(imem_req_o), 32'd0);
    tick();
    rlat = 1;
    expect_pc(32'h200); expect_pc(32'h204);
    stall_i = 1'b0;
    wait_drain("br");
    stall_i = 1'b1;

    // Trap wins over jump and branch
    wait_valid("prio");
    redirect("prio", 1'b1, 1'b1, 32'h80, 1'b1, 32'h40, TRAP_VEC);
    expect_pc(32'h100); expect_pc(32'h104);
    stall_i = 1'b0;
    wait_drain("prio");
    stall_i = 1'b1;

    // Misaligned jump target
    wait_valid("mis");
    redirect("mis", 1'b0, 1'b1, 32'h202, 1'b0, 32'h0, MIS_TGT);
    expect_pc(MIS_TGT); expect_pc(MIS_TGT + 32'h4);
    stall_i = 1'b0;
    wait_drain("mis");
    stall_i = 1'b1;

    // Reset while waiting; the stale response must be ignored
    rlat = 3;
    wait_valid("rst_wait");
    expect_pc(MIS_TGT + 32'h8);
    stall_i = 1'b0;
    wait_grant("rst_wait");
    reset = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req_o), 32'd0);
    check("midrst_valid", 32'(if_valid_o), 32'd0);
    check("midrst_pc", if_pc_o, 32'h0);
    check("midrst_instr", if_instr_o, NOP);
    check("midrst_flush", 32'(flush_o), 32'd0);
    check("midrst_addr", imem_addr_o, 32'h0);
    tick();
    reset = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4);
    wait_drain("after_rst");
    stall_i = 1'b1;
    rlat = 1;

    // PC wraps past 0xFFFF_FFFC
    wait_valid("wrap");
    redirect("wrap", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC);
    expect_pc(32'hFFFF_FFFC); expect_pc(32'h0); expect_pc(32'h4);
    stall_i = 1'b0;
    wait_drain("wrap");
    stall_i = 1'b1;

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
